// File: rtl/vid_pkg.sv
// rtl/vid_pkg.sv - 640x480 scanout timing constants, framebuffer defaults and shared types
package vid_pkg;

    localparam int CNT_W         = 10;
    localparam int COLOR_W       = 7;
    localparam int FB_WIDTH_DEF  = 160;
    localparam int FB_HEIGHT_DEF = 240;

    localparam logic [CNT_W-1:0] H_ACTIVE = 10'd640;
    localparam logic [CNT_W-1:0] H_FP     = 10'd16;
    localparam logic [CNT_W-1:0] H_SYNC   = 10'd96;
    localparam logic [CNT_W-1:0] H_TOTAL  = 10'd800;
    localparam logic [CNT_W-1:0] V_ACTIVE = 10'd480;
    localparam logic [CNT_W-1:0] V_FP     = 10'd10;
    localparam logic [CNT_W-1:0] V_SYNC   = 10'd2;
    localparam logic [CNT_W-1:0] V_TOTAL  = 10'd525;

    localparam logic [CNT_W-1:0] H_SYNC_START = H_ACTIVE + H_FP;
    localparam logic [CNT_W-1:0] H_SYNC_STOP  = H_SYNC_START + H_SYNC;
    localparam logic [CNT_W-1:0] V_SYNC_START = V_ACTIVE + V_FP;
    localparam logic [CNT_W-1:0] V_SYNC_STOP  = V_SYNC_START + V_SYNC;

    typedef struct packed {
        logic [CNT_W-1:0] v;
        logic [CNT_W-1:0] h;
    } pos_t;

    function automatic logic is_active(pos_t p);
        return (p.h < H_ACTIVE) && (p.v < V_ACTIVE);
    endfunction

endpackage

// File: rtl/vid_timing.sv
// rtl/vid_timing.sv - h/v pixel counters with sync, de and frame decoded two ticks behind the counter
module vid_timing
    import vid_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    output pos_t pos_o,
    output logic act_dly_o,
    output logic hsync_o,
    output logic vsync_o,
    output logic de_o,
    output logic frame_o
);

    pos_t cnt_q;
    pos_t pos_dly_q;
    pos_t cnt_nxt;

    always_comb begin
        cnt_nxt = cnt_q;
        if (cnt_q.h == H_TOTAL - 10'd1) begin
            cnt_nxt.h = '0;
            cnt_nxt.v = (cnt_q.v == V_TOTAL - 10'd1) ? '0 : cnt_q.v + 10'd1;
        end else begin
            cnt_nxt.h = cnt_q.h + 10'd1;
        end
    end

    // The delay stage resets to the last position of a frame so (0,0) appears two ticks after release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            pos_dly_q <= '{v: V_TOTAL - 10'd1, h: H_TOTAL - 10'd1};
            hsync_o   <= 1'b1;
            vsync_o   <= 1'b1;
            de_o      <= 1'b0;
            frame_o   <= 1'b0;
        end else begin
            frame_o <= 1'b0;
            if (tick_i) begin
                cnt_q     <= cnt_nxt;
                pos_dly_q <= cnt_q;
                hsync_o   <= !((pos_dly_q.h >= H_SYNC_START) && (pos_dly_q.h < H_SYNC_STOP));
                vsync_o   <= !((pos_dly_q.v >= V_SYNC_START) && (pos_dly_q.v < V_SYNC_STOP));
                de_o      <= act_dly_o;
                frame_o   <= (pos_dly_q == '0);
            end
        end
    end

    assign pos_o     = cnt_q;
    assign act_dly_o = is_active(pos_dly_q);

endmodule

// File: rtl/vid_scanout.sv
// rtl/vid_scanout.sv - 640x480 scanout of a 4x/2x scaled framebuffer; VID_LINEBUF_EN replays odd lines from a line buffer
module vid_scanout
    import vid_pkg::*;
#(
    parameter int FB_WIDTH   = FB_WIDTH_DEF,
    parameter int FB_HEIGHT  = FB_HEIGHT_DEF,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  pix_en_i,
    output logic                  fb_rd_o,
    output logic [ADDR_WIDTH-1:0] fb_addr_o,
    input  logic [COLOR_W-1:0]    fb_dat_i,
    output logic [COLOR_W-1:0]    color_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  de_o,
    output logic                  frame_o
);

    pos_t                  pos;
    logic                  act_dly;
    logic                  fetch;
    logic                  fb_fetch;
    logic                  req;
    logic                  cap_q;
    logic [COLOR_W-1:0]    pix_q;
    logic [COLOR_W-1:0]    pix_new;
    logic [COLOR_W-1:0]    pix_cur;
    logic [ADDR_WIDTH-1:0] rd_addr;

    vid_timing u_timing (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .tick_i    (pix_en_i),
        .pos_o     (pos),
        .act_dly_o (act_dly),
        .hsync_o   (hsync_o),
        .vsync_o   (vsync_o),
        .de_o      (de_o),
        .frame_o   (frame_o)
    );

    // One fetch per group of four pixels; rows past the framebuffer are never fetched.
    assign fetch   = pix_en_i && (pos.h[1:0] == 2'b00) && is_active(pos)
                     && (32'(pos.v >> 1) < 32'(FB_HEIGHT));
    assign rd_addr = ADDR_WIDTH'(32'(pos.v >> 1) * 32'(FB_WIDTH) + 32'(pos.h >> 2));

`ifdef VID_LINEBUF_EN
    localparam int COL_W = $clog2(FB_WIDTH);

    logic [COLOR_W-1:0] line_buf [FB_WIDTH];
    logic [COL_W-1:0]   col_q;
    logic               replay_q;
    logic               rd_q;

    assign fb_fetch = fetch && !pos.v[0];
    assign req      = rd_q;
    assign pix_new  = replay_q ? line_buf[col_q] : fb_dat_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q    <= '0;
            replay_q <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            rd_q <= fetch;
            if (fetch) begin
                col_q    <= COL_W'(pos.h >> 2);
                replay_q <= pos.v[0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (cap_q && !replay_q) begin
            line_buf[col_q] <= fb_dat_i;
        end
    end
`else
    assign fb_fetch = fetch;
    assign req      = fb_rd_o;
    assign pix_new  = fb_dat_i;
`endif

    // Forward the returning word so a tick landing on the capture cycle still sees it.
    assign pix_cur = cap_q ? pix_new : pix_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fb_rd_o   <= 1'b0;
            fb_addr_o <= '0;
            cap_q     <= 1'b0;
            pix_q     <= '0;
            color_o   <= '0;
        end else begin
            fb_rd_o <= fb_fetch;
            cap_q   <= req;
            if (fb_fetch) begin
                fb_addr_o <= rd_addr;
            end
            if (cap_q) begin
                pix_q <= pix_new;
            end
            if (pix_en_i) begin
                color_o <= act_dly ? pix_cur : '0;
            end
        end
    end

endmodule

// File: tb/tb_vid_scanout.sv
// tb/tb_vid_scanout.sv - randomized-cadence bench for vid_scanout against a position-based reference model
module tb_vid_scanout;

    localparam int FRAME = 800 * 525;
`ifdef VID_LINEBUF_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        fb_rd;
    logic [15:0] fb_addr;
    logic [6:0]  fb_dat = '0;
    logic [6:0]  color;
    logic        hs, vs, de, fr;

    int          n_run = 0;
    int          n_fail = 0;
    int          p = 0;
    int          idle_pulses = 0;
    logic        s_rd, s_hs, s_vs, s_de, s_fr, e_rd;
    logic [6:0]  s_col;
    logic [15:0] s_addr;
    logic [15:0] exp_addr = '0;
    logic [10:0] exp_out;

    vid_scanout dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .pix_en_i  (pix_en),
        .fb_rd_o   (fb_rd),
        .fb_addr_o (fb_addr),
        .fb_dat_i  (fb_dat),
        .color_o   (color),
        .hsync_o   (hs),
        .vsync_o   (vs),
        .de_o      (de),
        .frame_o   (fr)
    );

    always #5 clk = ~clk;

    // Framebuffer model: word at addr is addr[6:0], valid only the cycle after the strobe.
    always @(posedge clk) fb_dat <= fb_rd ? fb_addr[6:0] : 7'($urandom);

    function automatic int q_of(int pp);
        return (pp - 2 + FRAME) % FRAME;
    endfunction

    function automatic logic [10:0] m_out(int q);
        int   h, v;
        logic a;
        h = q % 800;
        v = q / 800;
        a = (h < 640) && (v < 480);
        m_out = {!(h >= 656 && h < 752), !(v >= 490 && v < 492), a, q == 0,
                 a ? 7'(((v / 2) * 160 + h / 4) % 128) : 7'd0};
    endfunction

    function automatic bit m_fetch(int pp);
        int c, h, v;
        c = pp % FRAME;
        h = c % 800;
        v = c / 800;
        return (h % 4 == 0) && (h < 640) && (v < 480) && !(LB && (v % 2 == 1));
    endfunction

    function automatic logic [15:0] m_addr(int pp);
        int c;
        c = pp % FRAME;
        return 16'(((c / 800) / 2) * 160 + (c % 800) / 4);
    endfunction

    task automatic step();
        @(negedge clk);
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        s_rd = fb_rd; s_addr = fb_addr; s_col = color;
        s_hs = hs; s_vs = vs; s_de = de; s_fr = fr;
        e_rd = rst_n && m_fetch(p);
        if (e_rd) exp_addr = m_addr(p);
        p = rst_n ? p + 1 : 0;
        repeat ($urandom_range(0, 1)) begin
            @(negedge clk);
            if (fb_rd || fr) idle_pulses++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            step();
            n_run++;
            if ({s_rd, s_hs, s_vs, s_de, s_fr, s_col, s_addr} !== {5'b01100, 7'd0, 16'd0}) begin
                n_fail++;
                $display("FAIL reset: got rd=%b hs=%b vs=%b de=%b fr=%b col=%h addr=%h want 0 1 1 0 0 00 0000",
                         s_rd, s_hs, s_vs, s_de, s_fr, s_col, s_addr);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        p = 0;
        exp_addr = '0;
        idle_pulses = 0;
    endtask

    task automatic test_sync_timing();
        int hs_low = 0;
        int de_hi = 0;
        for (int i = 0; i < 2400; i++) begin
            step();
            exp_out = m_out(q_of(p));
            n_run++;
            if ({s_hs, s_vs, s_de, s_fr} !== exp_out[10:7]) begin
                n_fail++;
                $display("FAIL sync p=%0d: got hs/vs/de/fr=%b want %b", p, {s_hs, s_vs, s_de, s_fr}, exp_out[10:7]);
            end
            if (q_of(p) < 1600) begin
                hs_low += int'(!s_hs);
                de_hi  += int'(s_de);
            end
        end
        n_run++;
        if (hs_low != 192 || de_hi != 1280) begin
            n_fail++;
            $display("FAIL sync_counts: got hsync_low=%0d de_high=%0d want 192 1280", hs_low, de_hi);
        end
    endtask

    task automatic test_addressing();
        for (int i = 0; i < 800; i++) begin
            step();
            exp_out = m_out(q_of(p));
            n_run++;
            if ({s_hs, s_vs, s_de, s_fr, s_col} !== exp_out || {s_rd, s_addr} !== {e_rd, exp_addr}) begin
                n_fail++;
                $display("FAIL scan p=%0d: got out=%h rd=%b addr=%0d want out=%h rd=%b addr=%0d",
                         p, {s_hs, s_vs, s_de, s_fr, s_col}, s_rd, s_addr, exp_out, e_rd, exp_addr);
            end
            if (p == 2409) begin
                n_run++;
                if ({s_rd, s_addr} !== {!LB, LB ? 16'd319 : 16'd162}) begin
                    n_fail++;
                    $display("FAIL addr_v3_h8: got rd=%b addr=%0d want rd=%b addr=%0d",
                             s_rd, s_addr, !LB, LB ? 319 : 162);
                end
            end
            if (p >= 2410 && p <= 2413) begin
                n_run++;
                if (s_col !== 7'h22) begin
                    n_fail++;
                    $display("FAIL color_v3_h8 p=%0d: got %h want 22", p, s_col);
                end
            end
        end
    endtask

    task automatic test_read_count();
        logic [6:0] line_col [640];
        int         rd_cnt = 0;
        int         q;
        idle_pulses = 0;
        for (int i = 0; i < 4800; i++) begin
            step();
            q = q_of(p);
            exp_out = m_out(q);
            rd_cnt += int'(s_rd);
            n_run++;
            if ({s_hs, s_vs, s_de, s_fr, s_col} !== exp_out || {s_rd, s_addr} !== {e_rd, exp_addr}) begin
                n_fail++;
                $display("FAIL scan p=%0d: got out=%h rd=%b addr=%0d want out=%h rd=%b addr=%0d",
                         p, {s_hs, s_vs, s_de, s_fr, s_col}, s_rd, s_addr, exp_out, e_rd, exp_addr);
            end
            if (exp_out[8]) begin
                if ((q / 800) % 2 == 0) begin
                    line_col[q % 800] = exp_out[6:0];
                end else begin
                    n_run++;
                    if (s_col !== line_col[q % 800]) begin
                        n_fail++;
                        $display("FAIL odd_line q=%0d: got %h want %h", q, s_col, line_col[q % 800]);
                    end
                end
            end
        end
        n_run++;
        if (rd_cnt + idle_pulses != (LB ? 480 : 960)) begin
            n_fail++;
            $display("FAIL read_count: got %0d want %0d", rd_cnt + idle_pulses, LB ? 480 : 960);
        end
    endtask

    task automatic test_stall();
        while (p % 800 != 300) step();
        exp_out = m_out(q_of(p));
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_run++;
            if ({fb_rd, hs, vs, de, fr, color, fb_addr} !== {1'b0, exp_out, exp_addr}) begin
                n_fail++;
                $display("FAIL stall cyc=%0d: got rd=%b out=%h addr=%0d want rd=0 out=%h addr=%0d",
                         i, fb_rd, {hs, vs, de, fr, color}, fb_addr, exp_out, exp_addr);
            end
        end
        step();
        exp_out = m_out(q_of(p));
        n_run++;
        if ({s_rd, s_addr, s_hs, s_vs, s_de, s_fr, s_col} !== {1'b1, 16'd875, exp_out}) begin
            n_fail++;
            $display("FAIL stall_resume: got rd=%b addr=%0d out=%h want rd=1 addr=875 out=%h",
                     s_rd, s_addr, {s_hs, s_vs, s_de, s_fr, s_col}, exp_out);
        end
    endtask

    task automatic test_mid_reset();
        repeat (50) step();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_run++;
            if ({s_rd, s_hs, s_vs, s_de, s_fr, s_col, s_addr} !== {5'b01100, 7'd0, 16'd0}) begin
                n_fail++;
                $display("FAIL mid_reset: got rd=%b hs=%b vs=%b de=%b fr=%b col=%h addr=%h want 0 1 1 0 0 00 0000",
                         s_rd, s_hs, s_vs, s_de, s_fr, s_col, s_addr);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        p = 0;
        exp_addr = '0;
        step();
        n_run++;
        if ({s_rd, s_addr, s_fr} !== {1'b1, 16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL restart_first_tick: got rd=%b addr=%0d fr=%b want 1 0 0", s_rd, s_addr, s_fr);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            exp_out = m_out(q_of(p));
            n_run++;
            if ({s_hs, s_vs, s_de, s_fr, s_col} !== exp_out || {s_rd, s_addr} !== {e_rd, exp_addr}) begin
                n_fail++;
                $display("FAIL restart p=%0d: got out=%h rd=%b addr=%0d want out=%h rd=%b addr=%0d",
                         p, {s_hs, s_vs, s_de, s_fr, s_col}, s_rd, s_addr, exp_out, e_rd, exp_addr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sync_timing();
        test_addressing();
        test_read_count();
        test_stall();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
